parity_checker_core: RTL and testbench

Registered, parameterizable parity checker. It sits on the receive side of a parallel data path. Each cycle it checks an incoming data word against its accompanying parity bit, flags whether parity holds, and keeps a sticky error flag plus a saturating error counter for status readout. Even parity is the default: the total number of ones across `data_in` and `parity_bit` must be even.

---
 rtl/parity_checker_core.sv | 101 ++++++++++
 tb/tb_parity_checker_core.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/parity_checker_core.sv
`default_nettype none
// ============================================================================
// Module      : parity_checker_core
// Description : Registered parity checker for a parallel receive path.
//               Flags per-word parity status one cycle after each valid
//               word, and keeps a sticky error flag plus a saturating
//               error counter for status readout.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_checker_core #(
    parameter int WIDTH      = 8,
    parameter int ODD_PARITY = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 parity_bit,
    input  logic                 valid_in,
    input  logic                 clear_err,
    output logic                 parity_ok,
    output logic                 valid_out,
    output logic                 expected_parity,
    output logic                 err_sticky,
    output logic [CNT_WIDTH-1:0] err_count
);

    // Parity sense folded into a single bit so it can be XORed directly.
    localparam logic                 c_odd     = (ODD_PARITY != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 w_calc;
    logic                 w_expected;
    logic                 w_fail;
    logic [CNT_WIDTH-1:0] w_cnt_base;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic                 w_sticky_next;

    logic                 r_parity_ok;
    logic                 r_valid_out;
    logic                 r_expected_parity;
    logic                 r_err_sticky;
    logic [CNT_WIDTH-1:0] r_err_count;

    // Parity check of the incoming word; WIDTH=1 reduces to data_in[0].
    always_comb begin
        w_calc     = ^data_in;
        w_expected = w_calc ^ c_odd;
        w_fail     = valid_in & (parity_bit != w_expected);
    end

    // Error status next-state: a clear is applied first, then any failure
    // in the same cycle is recorded on top of the cleared value.
    always_comb begin
        w_cnt_base    = clear_err ? '0 : r_err_count;
        w_cnt_next    = w_cnt_base;
        w_sticky_next = clear_err ? 1'b0 : r_err_sticky;
        if (w_fail) begin
            w_sticky_next = 1'b1;
            if (w_cnt_base != c_cnt_max) begin
                w_cnt_next = w_cnt_base + c_cnt_one;
            end
        end
    end

    // Per-word result registers; hold on idle cycles, pulse valid_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_ok       <= 1'b1;
            r_valid_out       <= 1'b0;
            r_expected_parity <= 1'b0;
        end else begin
            r_valid_out <= valid_in;
            if (valid_in) begin
                r_parity_ok       <= ~w_fail;
                r_expected_parity <= w_expected;
            end
        end
    end

    // Sticky error flag and saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_err_sticky <= w_sticky_next;
            r_err_count  <= w_cnt_next;
        end
    end

    // All outputs come straight from registers.
    assign parity_ok       = r_parity_ok;
    assign valid_out       = r_valid_out;
    assign expected_parity = r_expected_parity;
    assign err_sticky      = r_err_sticky;
    assign err_count       = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_parity_checker_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_checker_core
// Description : Self-checking bench for parity_checker_core. Table-driven
//               vectors on the default configuration plus hand sequences
//               for reset, counter saturation, odd parity and WIDTH=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_checker_core;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       parity_bit;
    logic       valid_in;
    logic       clear_err;

    logic        ok_d, vout_d, expp_d, sticky_d;
    logic [15:0] cnt_d;
    logic        ok_s, vout_s, expp_s, sticky_s;
    logic [1:0]  cnt_s;
    logic        ok_o, vout_o, expp_o, sticky_o;
    logic [15:0] cnt_o;
    logic        ok_w, vout_w, expp_w, sticky_w;
    logic [15:0] cnt_w;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    parity_checker_core #(.WIDTH(8), .ODD_PARITY(0), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .parity_bit(parity_bit),
        .valid_in(valid_in), .clear_err(clear_err), .parity_ok(ok_d),
        .valid_out(vout_d), .expected_parity(expp_d), .err_sticky(sticky_d),
        .err_count(cnt_d)
    );

    parity_checker_core #(.WIDTH(8), .ODD_PARITY(0), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .data_in(data_in), .parity_bit(parity_bit),
        .valid_in(valid_in), .clear_err(clear_err), .parity_ok(ok_s),
        .valid_out(vout_s), .expected_parity(expp_s), .err_sticky(sticky_s),
        .err_count(cnt_s)
    );

    parity_checker_core #(.WIDTH(8), .ODD_PARITY(1), .CNT_WIDTH(16)) dut_odd (
        .clk(clk), .rst(rst), .data_in(data_in), .parity_bit(parity_bit),
        .valid_in(valid_in), .clear_err(clear_err), .parity_ok(ok_o),
        .valid_out(vout_o), .expected_parity(expp_o), .err_sticky(sticky_o),
        .err_count(cnt_o)
    );

    parity_checker_core #(.WIDTH(1), .ODD_PARITY(0), .CNT_WIDTH(16)) dut_w1 (
        .clk(clk), .rst(rst), .data_in(data_in[0:0]), .parity_bit(parity_bit),
        .valid_in(valid_in), .clear_err(clear_err), .parity_ok(ok_w),
        .valid_out(vout_w), .expected_parity(expp_w), .err_sticky(sticky_w),
        .err_count(cnt_w)
    );

    typedef struct {
        logic [7:0]  data;
        logic        par;
        logic        valid;
        logic        clr;
        logic        exp_ok;
        logic        exp_vout;
        logic        exp_expp;
        logic        exp_sticky;
        logic [15:0] exp_cnt;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the next rise.
    task automatic cycle(input logic r, input logic [7:0] d, input logic p,
                         input logic v, input logic c);
        @(negedge clk);
        rst        = r;
        data_in    = d;
        parity_bit = p;
        valid_in   = v;
        clear_err  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input logic ok, input logic vo,
                            input logic ep, input logic st, input logic [15:0] cn);
        chk({tag, ".parity_ok"},       {31'd0, ok_d},     {31'd0, ok});
        chk({tag, ".valid_out"},       {31'd0, vout_d},   {31'd0, vo});
        chk({tag, ".expected_parity"}, {31'd0, expp_d},   {31'd0, ep});
        chk({tag, ".err_sticky"},      {31'd0, sticky_d}, {31'd0, st});
        chk({tag, ".err_count"},       {16'd0, cnt_d},    {16'd0, cn});
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //          data   par   vld   clr   ok    vout  expp  stk   cnt
        vecs[0]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
        vecs[2]  = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1};
        vecs[3]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1};
        vecs[4]  = '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2};
        vecs[5]  = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2};
        vecs[6]  = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2};
        vecs[7]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[8]  = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
        vecs[9]  = '{8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1};
        vecs[10] = '{8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1};
        vecs[11] = '{8'hAA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2};
        vecs[12] = '{8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};

        rst = 1'b1; data_in = 8'h00; parity_bit = 1'b0; valid_in = 1'b0; clear_err = 1'b0;

        // Reset, with valid and clear asserted to show they are ignored.
        cycle(1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
        chk_main("reset", 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk_main("idle", 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);

        // Table-driven main sequence.
        for (int i = 0; i < NVEC; i++) begin
            cycle(1'b0, vecs[i].data, vecs[i].par, vecs[i].valid, vecs[i].clr);
            chk_main($sformatf("vec%0d", i), vecs[i].exp_ok, vecs[i].exp_vout,
                     vecs[i].exp_expp, vecs[i].exp_sticky, vecs[i].exp_cnt);
        end

        // Reset arriving the cycle after a failing valid word.
        cycle(1'b0, 8'h01, 1'b0, 1'b1, 1'b0);
        chk_main("pre_rst", 1'b0, 1'b1, 1'b1, 1'b1, 16'd1);
        cycle(1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
        chk_main("rst_inflight", 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);

        // Saturation on the 2-bit counter; main counter keeps counting.
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b0, 8'h01, 1'b0, 1'b1, 1'b0);
            chk($sformatf("sat%0d.err_count", k), {30'd0, cnt_s},
                (k >= 3) ? 32'd3 : k);
            chk($sformatf("sat%0d.err_sticky", k), {31'd0, sticky_s}, 32'd1);
            chk($sformatf("sat%0d.main_count", k), {16'd0, cnt_d}, k);
        end

        // Odd parity and WIDTH=1 on fresh state.
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("odd_00p1.parity_ok",       {31'd0, ok_o},   32'd1);
        chk("odd_00p1.expected_parity", {31'd0, expp_o}, 32'd1);
        chk("w1_0p1.parity_ok",         {31'd0, ok_w},   32'd0);
        chk("w1_0p1.err_count",         {16'd0, cnt_w},  32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("odd_00p0.parity_ok",       {31'd0, ok_o},   32'd0);
        chk("odd_00p0.err_count",       {16'd0, cnt_o},  32'd1);
        chk("w1_0p0.parity_ok",         {31'd0, ok_w},   32'd1);
        cycle(1'b0, 8'h01, 1'b1, 1'b1, 1'b0);
        chk("odd_01p1.parity_ok",       {31'd0, ok_o},   32'd0);
        chk("odd_01p1.expected_parity", {31'd0, expp_o}, 32'd0);
        chk("w1_1p1.parity_ok",         {31'd0, ok_w},   32'd1);
        chk("w1_1p1.expected_parity",   {31'd0, expp_w}, 32'd1);
        chk("w1_1p1.valid_out",         {31'd0, vout_w}, 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("w1_idle.valid_out",        {31'd0, vout_w}, 32'd0);
        chk("odd_idle.err_sticky",      {31'd0, sticky_o}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
